// File: rtl/calc_in_unit.sv
// calc_in_unit: decimal operand entry for the 8-bit calculator.
// Collects up to three digits plus sign and issues a two's-complement operand.
module calc_in_unit (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       KeyValid,
    input  logic [3:0] KeyCode,
    output logic [7:0] EntryValue,
    output logic       EntryValid,
    output logic       Neg,
    output logic       Err,
    output logic [3:0] Ones,
    output logic [3:0] Tens,
    output logic [1:0] Hundreds
);

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        DONE,
        ERROR
    } state_t;

    state_t      state, state_n;
    logic        kv_q;
    logic [7:0]  mag, mag_n;
    logic [1:0]  cnt, cnt_n;
    logic [3:0]  ones_n, tens_n;
    logic [1:0]  hund_n;
    logic        neg_n, err_n, vld_n;
    logic [7:0]  val_n;

    logic        ev, dig, sgn, clr, ent;
    logic [10:0] prod;
    logic        ovf;
    logic [7:0]  sval;

    assign ev   = KeyValid & ~kv_q;
    assign dig  = ev && (KeyCode <= 4'd9);
    assign sgn  = ev && (KeyCode == 4'd10);
    assign clr  = ev && (KeyCode == 4'd11);
    assign ent  = ev && (KeyCode == 4'd12);
    assign prod = 11'(mag) * 11'd10 + 11'(KeyCode);
    assign ovf  = prod > 11'd127;
    assign sval = Neg ? (~mag + 8'd1) : mag;

    always_comb begin
        state_n = state;
        mag_n   = mag;
        cnt_n   = cnt;
        ones_n  = Ones;
        tens_n  = Tens;
        hund_n  = Hundreds;
        neg_n   = Neg;
        err_n   = Err;
        val_n   = EntryValue;
        vld_n   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                unique case (1'b1)
                    dig: begin
                        // A digit after DONE starts over from a blank entry
                        if (state == DONE) begin
                            mag_n   = 8'd0;
                            cnt_n   = 2'd0;
                            ones_n  = 4'd0;
                            tens_n  = 4'd0;
                            hund_n  = 2'd0;
                            neg_n   = 1'b0;
                            state_n = IDLE;
                        end
                        if (KeyCode != 4'd0) begin
                            mag_n   = {4'd0, KeyCode};
                            cnt_n   = 2'd1;
                            ones_n  = KeyCode;
                            tens_n  = 4'd0;
                            hund_n  = 2'd0;
                            state_n = ENTRY;
                        end
                    end
                    sgn: neg_n = ~Neg;
                    clr: begin
                        mag_n   = 8'd0;
                        cnt_n   = 2'd0;
                        ones_n  = 4'd0;
                        tens_n  = 4'd0;
                        hund_n  = 2'd0;
                        neg_n   = 1'b0;
                        state_n = IDLE;
                    end
                    ent: begin
                        if (state == IDLE) begin
                            val_n = 8'd0;
                            neg_n = 1'b0;
                        end else begin
                            val_n = sval;
                        end
                        vld_n   = 1'b1;
                        state_n = DONE;
                    end
                    default: ;
                endcase
            end
            ENTRY: begin
                unique case (1'b1)
                    dig: begin
                        if (cnt != 2'd3) begin
                            if (ovf) begin
                                err_n   = 1'b1;
                                state_n = ERROR;
                            end else begin
                                mag_n  = prod[7:0];
                                hund_n = Tens[1:0];
                                tens_n = Ones;
                                ones_n = KeyCode;
                                cnt_n  = cnt + 2'd1;
                            end
                        end
                    end
                    sgn: neg_n = ~Neg;
                    clr: begin
                        mag_n   = 8'd0;
                        cnt_n   = 2'd0;
                        ones_n  = 4'd0;
                        tens_n  = 4'd0;
                        hund_n  = 2'd0;
                        neg_n   = 1'b0;
                        state_n = IDLE;
                    end
                    ent: begin
                        val_n   = sval;
                        vld_n   = 1'b1;
                        state_n = DONE;
                    end
                    default: ;
                endcase
            end
            ERROR: begin
                if (clr) begin
                    mag_n   = 8'd0;
                    cnt_n   = 2'd0;
                    ones_n  = 4'd0;
                    tens_n  = 4'd0;
                    hund_n  = 2'd0;
                    neg_n   = 1'b0;
                    err_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            kv_q       <= 1'b0;
            mag        <= 8'd0;
            cnt        <= 2'd0;
            Ones       <= 4'd0;
            Tens       <= 4'd0;
            Hundreds   <= 2'd0;
            Neg        <= 1'b0;
            Err        <= 1'b0;
            EntryValue <= 8'd0;
            EntryValid <= 1'b0;
        end else begin
            state      <= state_n;
            kv_q       <= KeyValid;
            mag        <= mag_n;
            cnt        <= cnt_n;
            Ones       <= ones_n;
            Tens       <= tens_n;
            Hundreds   <= hund_n;
            Neg        <= neg_n;
            Err        <= err_n;
            EntryValue <= val_n;
            EntryValid <= vld_n;
        end
    end

endmodule

// File: tb/tb_calc_in_unit.sv
// tb_calc_in_unit: key-sequence table plus scoreboard of issued operands.
// Hand-written sequences cover key hold and asynchronous reset.
module tb_calc_in_unit;

    logic       CLK;
    logic       Reset;
    logic       KeyValid;
    logic [3:0] KeyCode;
    logic [7:0] EntryValue;
    logic       EntryValid;
    logic       Neg;
    logic       Err;
    logic [3:0] Ones;
    logic [3:0] Tens;
    logic [1:0] Hundreds;

    calc_in_unit dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .KeyValid  (KeyValid),
        .KeyCode   (KeyCode),
        .EntryValue(EntryValue),
        .EntryValid(EntryValid),
        .Neg       (Neg),
        .Err       (Err),
        .Ones      (Ones),
        .Tens      (Tens),
        .Hundreds  (Hundreds)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] code;
        logic       pulse;
        logic [7:0] val;
        logic       neg;
        logic       err;
        logic [1:0] h;
        logic [3:0] t;
        logic [3:0] o;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] exp_q[$];
    int         total = 0;
    int         bad = 0;
    logic       vld_prev = 1'b0;

    function automatic vec_t v(input logic [3:0] code, input logic pulse,
                               input logic [7:0] val, input logic neg,
                               input logic err, input logic [1:0] h,
                               input logic [3:0] t, input logic [3:0] o);
        vec_t r;
        r.code = code; r.pulse = pulse; r.val = val; r.neg = neg;
        r.err = err; r.h = h; r.t = t; r.o = o;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic key(input logic [3:0] code);
        KeyCode  = code;
        KeyValid = 1'b1;
        @(negedge CLK);
        KeyValid = 1'b0;
        @(negedge CLK);
    endtask

    function automatic logic [31:0] echo();
        return {20'd0, Neg, Err, Hundreds, Tens, Ones};
    endfunction

    function automatic logic [31:0] all_out();
        return {11'd0, EntryValue, EntryValid, Neg, Err, Hundreds, Tens, Ones};
    endfunction

    always @(negedge CLK) begin
        if (!Reset && EntryValid) begin
            total++;
            if (vld_prev) begin
                bad++;
                $display("FAIL pulse_width: valid high two cycles, val %h", EntryValue);
            end else if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got %h want none", EntryValue);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (EntryValue !== e) begin
                    bad++;
                    $display("FAIL entry_value: got %h want %h", EntryValue, e);
                end
            end
        end
        vld_prev = Reset ? 1'b0 : EntryValid;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl.push_back(v(4'd1,  0, 8'h00, 0, 0, 2'd0, 4'd0, 4'd1));
        tbl.push_back(v(4'd2,  0, 8'h00, 0, 0, 2'd0, 4'd1, 4'd2));
        tbl.push_back(v(4'd7,  0, 8'h00, 0, 0, 2'd1, 4'd2, 4'd7));
        tbl.push_back(v(4'd12, 1, 8'h7F, 0, 0, 2'd1, 4'd2, 4'd7));
        tbl.push_back(v(4'd10, 0, 8'h00, 1, 0, 2'd1, 4'd2, 4'd7));
        tbl.push_back(v(4'd12, 1, 8'h81, 1, 0, 2'd1, 4'd2, 4'd7));
        tbl.push_back(v(4'd11, 0, 8'h00, 0, 0, 2'd0, 4'd0, 4'd0));
        tbl.push_back(v(4'd10, 0, 8'h00, 1, 0, 2'd0, 4'd0, 4'd0));
        tbl.push_back(v(4'd4,  0, 8'h00, 1, 0, 2'd0, 4'd0, 4'd4));
        tbl.push_back(v(4'd5,  0, 8'h00, 1, 0, 2'd0, 4'd4, 4'd5));
        tbl.push_back(v(4'd12, 1, 8'hD3, 1, 0, 2'd0, 4'd4, 4'd5));
        tbl.push_back(v(4'd12, 1, 8'hD3, 1, 0, 2'd0, 4'd4, 4'd5));
        tbl.push_back(v(4'd1,  0, 8'h00, 0, 0, 2'd0, 4'd0, 4'd1));
        tbl.push_back(v(4'd2,  0, 8'h00, 0, 0, 2'd0, 4'd1, 4'd2));
        tbl.push_back(v(4'd8,  0, 8'h00, 0, 1, 2'd0, 4'd1, 4'd2));
        tbl.push_back(v(4'd12, 0, 8'h00, 0, 1, 2'd0, 4'd1, 4'd2));
        tbl.push_back(v(4'd10, 0, 8'h00, 0, 1, 2'd0, 4'd1, 4'd2));
        tbl.push_back(v(4'd5,  0, 8'h00, 0, 1, 2'd0, 4'd1, 4'd2));
        tbl.push_back(v(4'd11, 0, 8'h00, 0, 0, 2'd0, 4'd0, 4'd0));
        tbl.push_back(v(4'd0,  0, 8'h00, 0, 0, 2'd0, 4'd0, 4'd0));
        tbl.push_back(v(4'd0,  0, 8'h00, 0, 0, 2'd0, 4'd0, 4'd0));
        tbl.push_back(v(4'd9,  0, 8'h00, 0, 0, 2'd0, 4'd0, 4'd9));
        tbl.push_back(v(4'd12, 1, 8'h09, 0, 0, 2'd0, 4'd0, 4'd9));
        tbl.push_back(v(4'd10, 0, 8'h00, 1, 0, 2'd0, 4'd0, 4'd9));
        tbl.push_back(v(4'd12, 1, 8'hF7, 1, 0, 2'd0, 4'd0, 4'd9));
        tbl.push_back(v(4'd13, 0, 8'h00, 1, 0, 2'd0, 4'd0, 4'd9));
        tbl.push_back(v(4'd0,  0, 8'h00, 0, 0, 2'd0, 4'd0, 4'd0));
        tbl.push_back(v(4'd12, 1, 8'h00, 0, 0, 2'd0, 4'd0, 4'd0));
        tbl.push_back(v(4'd1,  0, 8'h00, 0, 0, 2'd0, 4'd0, 4'd1));
        tbl.push_back(v(4'd1,  0, 8'h00, 0, 0, 2'd0, 4'd1, 4'd1));
        tbl.push_back(v(4'd1,  0, 8'h00, 0, 0, 2'd1, 4'd1, 4'd1));
        tbl.push_back(v(4'd1,  0, 8'h00, 0, 0, 2'd1, 4'd1, 4'd1));
        tbl.push_back(v(4'd15, 0, 8'h00, 0, 0, 2'd1, 4'd1, 4'd1));
        tbl.push_back(v(4'd11, 0, 8'h00, 0, 0, 2'd0, 4'd0, 4'd0));
        tbl.push_back(v(4'd10, 0, 8'h00, 1, 0, 2'd0, 4'd0, 4'd0));
        tbl.push_back(v(4'd12, 1, 8'h00, 0, 0, 2'd0, 4'd0, 4'd0));
        tbl.push_back(v(4'd1,  0, 8'h00, 0, 0, 2'd0, 4'd0, 4'd1));
        tbl.push_back(v(4'd0,  0, 8'h00, 0, 0, 2'd0, 4'd1, 4'd0));
        tbl.push_back(v(4'd12, 1, 8'h0A, 0, 0, 2'd0, 4'd1, 4'd0));

        Reset    = 1'b1;
        KeyValid = 1'b0;
        KeyCode  = 4'd0;
        #1;
        chk("reset_async", all_out(), 32'd0);
        repeat (3) @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        chk("reset_state", all_out(), 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].pulse) exp_q.push_back(tbl[i].val);
            key(tbl[i].code);
            chk($sformatf("vec%0d_echo", i), echo(),
                {20'd0, tbl[i].neg, tbl[i].err, tbl[i].h, tbl[i].t, tbl[i].o});
        end

        key(4'd11);
        KeyCode  = 4'd5;
        KeyValid = 1'b1;
        repeat (20) @(negedge CLK);
        chk("hold_one_digit", echo(), {20'd0, 4'b0000, 4'd0, 4'd5});
        KeyValid = 1'b0;
        @(negedge CLK);
        key(4'd4);
        chk("after_hold", echo(), {20'd0, 4'b0000, 4'd5, 4'd4});

        key(4'd11);
        key(4'd6);
        key(4'd3);
        chk("pre_reset_echo", echo(), {20'd0, 4'b0000, 4'd6, 4'd3});
        #2;
        Reset = 1'b1;
        #1;
        chk("reset_mid_entry", all_out(), 32'd0);
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);

        key(4'd6);
        key(4'd3);
        KeyCode  = 4'd12;
        KeyValid = 1'b1;
        @(posedge CLK);
        #1;
        chk("pulse_before_reset", {23'd0, EntryValid, EntryValue}, {23'd0, 1'b1, 8'h3F});
        Reset = 1'b1;
        #1;
        chk("reset_in_pulse", all_out(), 32'd0);
        @(negedge CLK);
        KeyValid = 1'b0;
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);

        key(4'd10);
        chk("idle_sign", echo(), {20'd0, 4'b1000, 4'd0, 4'd0});
        exp_q.push_back(8'h00);
        key(4'd12);
        chk("idle_enter_neg", echo(), 32'd0);

        Reset    = 1'b1;
        KeyCode  = 4'd7;
        KeyValid = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        chk("held_through_reset", echo(), {20'd0, 4'b0000, 4'd0, 4'd7});
        KeyValid = 1'b0;
        repeat (3) @(negedge CLK);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_pulses: got %0d left want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
